// File: rtl/accelerator_hls_deadlock_pkg.sv
// Shared types and constants for the HLS deadlock report controller.
// Optional false-alarm counter width is used when ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN is defined.
package accelerator_hls_deadlock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WATCH   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_REPORT  = 3'd3,
    ST_HALT    = 3'd4
  } state_e;

  localparam int DEF_PERSIST_CYCLES = 16;
  localparam int FA_W               = 16;

endpackage

// File: rtl/accelerator_hls_deadlock_ffs.sv
// Lowest-set-bit finder with exactly-one-bit detect.
// Feeds the report index and last flag.
module accelerator_hls_deadlock_ffs
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          one
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

  always_comb begin
    one = (vec != '0) && ((vec & (vec - N'(1))) == '0);
  end

endmodule

// File: rtl/accelerator_hls_deadlock_report_ctrl.sv
// Deadlock confirm/report controller over per-process HLS monitors.
// Define ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN to add the false_alarm_cnt output.
module accelerator_hls_deadlock_report_ctrl
  import accelerator_hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC       = 4,
  parameter int PERSIST_CYCLES = DEF_PERSIST_CYCLES,
  parameter int CNT_W          = 8,
  parameter int TS_W           = 32,
  localparam int IW = (NUM_PROC > 1) ? $clog2(NUM_PROC) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                arm,
  input  logic                clear,
  input  logic [NUM_PROC-1:0] monitor_block,
  output logic                deadlock,
  output logic                busy,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [IW-1:0]       report_idx,
  output logic [TS_W-1:0]     report_onset,
  output logic                report_last
`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
  ,
  output logic [FA_W-1:0]     false_alarm_cnt
`endif
);

  state_e              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_PROC-1:0] mask_q, mask_d;
  logic [TS_W-1:0]     onset_q, onset_d;
  logic                dl_q, dl_d;

  logic [IW-1:0]       ffs_idx;
  logic                ffs_one;
  logic                any_blk;
  logic [CNT_W-1:0]    cnt_inc;
  logic [NUM_PROC-1:0] one_v;

  assign any_blk = |monitor_block;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign one_v   = NUM_PROC'(1);

  accelerator_hls_deadlock_ffs #(
    .N  (NUM_PROC),
    .IW (IW)
  ) u_ffs (
    .vec (mask_q),
    .idx (ffs_idx),
    .one (ffs_one)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ts_q    <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      onset_q <= '0;
      dl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      onset_q <= onset_d;
      dl_q    <= dl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_WATCH;
      end
      ST_WATCH: begin
        if (!arm) state_d = ST_IDLE;
        else if (any_blk)
          state_d = (PERSIST_CYCLES == 1) ? ST_REPORT : ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (!arm) state_d = ST_IDLE;
        else if (!any_blk) state_d = ST_WATCH;
        else if (cnt_inc == CNT_W'(PERSIST_CYCLES)) state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (report_ready && ffs_one) state_d = ST_HALT;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    if (clear) state_d = arm ? ST_WATCH : ST_IDLE;
  end

  // Timestamp: restarts on arming, saturates instead of wrapping.
  always_comb begin
    ts_d = ts_q;
    if (state_q == ST_IDLE) begin
      if (state_d == ST_WATCH) ts_d = '0;
    end else if (ts_q != {TS_W{1'b1}}) begin
      ts_d = ts_q + TS_W'(1);
    end
    if (clear) ts_d = '0;
  end

  always_comb begin
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    onset_d = onset_q;
    unique case (state_q)
      ST_WATCH: begin
        if (arm && any_blk) begin
          mask_d  = monitor_block;
          cnt_d   = CNT_W'(1);
          onset_d = ts_q;
        end
      end
      ST_CONFIRM: begin
        if (!arm || !any_blk) begin
          mask_d  = '0;
          cnt_d   = '0;
          onset_d = '0;
        end else begin
          mask_d = mask_q | monitor_block;
          cnt_d  = cnt_inc;
        end
      end
      ST_REPORT: begin
        if (report_ready) mask_d = mask_q & ~(one_v << ffs_idx);
      end
      default: ;
    endcase
    if (clear) begin
      mask_d  = '0;
      cnt_d   = '0;
      onset_d = '0;
    end
  end

  always_comb begin
    dl_d = dl_q | (state_d == ST_REPORT);
    if (clear) dl_d = 1'b0;
  end

  always_comb begin
    deadlock     = dl_q;
    busy         = (state_q == ST_CONFIRM) || (state_q == ST_REPORT);
    report_valid = (state_q == ST_REPORT);
    report_idx   = report_valid ? ffs_idx : '0;
    report_onset = report_valid ? onset_q : '0;
    report_last  = report_valid & ffs_one;
  end

`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
  logic [FA_W-1:0] fa_q, fa_d;

  always_comb begin
    fa_d = fa_q;
    if (state_q == ST_CONFIRM && arm && !any_blk && fa_q != {FA_W{1'b1}})
      fa_d = fa_q + FA_W'(1);
    if (clear) fa_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) fa_q <= '0;
    else       fa_q <= fa_d;
  end

  assign false_alarm_cnt = fa_q;
`endif

endmodule

// File: tb/tb_accelerator_hls_deadlock_report_ctrl.sv
// Directed bench for the deadlock report controller.
// Second instance covers PERSIST_CYCLES=1.
module tb_accelerator_hls_deadlock_report_ctrl;
  import accelerator_hls_deadlock_pkg::*;

  logic       clock = 0;
  logic       reset;
  logic       arm, clear, ready;
  logic [3:0] mb;
  logic       dl, busy, valid, last;
  logic [1:0] idx;
  logic [31:0] onset;

  logic       arm1, clear1, ready1;
  logic [3:0] mb1;
  logic       dl1, busy1, valid1, last1;
  logic [1:0] idx1;
  logic [31:0] onset1;

`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
  logic [15:0] fa, fa1;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  accelerator_hls_deadlock_report_ctrl dut (
    .clock(clock), .reset(reset), .arm(arm), .clear(clear),
    .monitor_block(mb), .deadlock(dl), .busy(busy),
    .report_valid(valid), .report_ready(ready), .report_idx(idx),
    .report_onset(onset), .report_last(last)
`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
    , .false_alarm_cnt(fa)
`endif
  );

  accelerator_hls_deadlock_report_ctrl #(.PERSIST_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .arm(arm1), .clear(clear1),
    .monitor_block(mb1), .deadlock(dl1), .busy(busy1),
    .report_valid(valid1), .report_ready(ready1), .report_idx(idx1),
    .report_onset(onset1), .report_last(last1)
`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
    , .false_alarm_cnt(fa1)
`endif
  );

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1; arm = 0; clear = 0; ready = 0; mb = 4'b0000;
    arm1 = 0; clear1 = 0; ready1 = 0; mb1 = 4'b0000;
    tick(2);
    reset = 0;
    check("rst_dl", 32'(dl), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_idx", 32'(idx), 32'd0);
    check("rst_onset", onset, 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Armed with no blocks: idle watching
    arm = 1;
    tick(101);
    check("watch_state", 32'(dut.state_q), 32'(ST_WATCH));
    check("watch_dl", 32'(dl), 32'd0);
    check("watch_valid", 32'(valid), 32'd0);

    // Single blocked process from ts=5
    clear = 1; tick(); clear = 0;
    tick(5);
    mb = 4'b0010; ready = 1;
    tick(15);
    check("t2_pre_dl", 32'(dl), 32'd0);
    check("t2_pre_busy", 32'(busy), 32'd1);
    tick();
    check("t2_dl", 32'(dl), 32'd1);
    check("t2_valid", 32'(valid), 32'd1);
    check("t2_idx", 32'(idx), 32'd1);
    check("t2_onset", onset, 32'd5);
    check("t2_last", 32'(last), 32'd1);
    tick();
    check("t2_halt_valid", 32'(valid), 32'd0);
    check("t2_halt_dl", 32'(dl), 32'd1);
    check("t2_halt_state", 32'(dut.state_q), 32'(ST_HALT));
    mb = 4'b0000; ready = 0;
    tick(3);
    check("t2_halt_hold", 32'(dl), 32'd1);

    // Mask accumulation and back-pressure
    clear = 1; tick(); clear = 0;
    check("t3_clr_dl", 32'(dl), 32'd0);
    tick(2);
    mb = 4'b0001;
    tick(3);
    mb = 4'b0100;
    tick(13);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_idx0", 32'(idx), 32'd0);
    check("t3_last0", 32'(last), 32'd0);
    check("t3_onset", onset, 32'd2);
    check("t3_dl", 32'(dl), 32'd1);
    mb = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t3_stall_valid", 32'(valid), 32'd1);
      check("t3_stall_idx", 32'(idx), 32'd0);
      check("t3_stall_last", 32'(last), 32'd0);
      check("t3_stall_onset", onset, 32'd2);
    end
    ready = 1;
    tick();
    check("t3_idx2", 32'(idx), 32'd2);
    check("t3_last2", 32'(last), 32'd1);
    check("t3_valid2", 32'(valid), 32'd1);
    tick();
    check("t3_done_valid", 32'(valid), 32'd0);
    check("t3_done_dl", 32'(dl), 32'd1);
    ready = 0; mb = 4'b0000;

    // Glitch then re-onset
    clear = 1; tick(); clear = 0;
    mb = 4'b1111;
    tick(10);
    check("t4_confirm_busy", 32'(busy), 32'd1);
    mb = 4'b0000;
    tick();
    check("t4_glitch_busy", 32'(busy), 32'd0);
    check("t4_glitch_dl", 32'(dl), 32'd0);
`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
    check("t4_fa", 32'(fa), 32'd1);
`endif
    mb = 4'b0001;
    for (int i = 0; i < 15; i++) begin
      tick();
      check("t4_no_dl", 32'(dl), 32'd0);
    end
    tick();
    check("t4_dl", 32'(dl), 32'd1);
    check("t4_onset", onset, 32'd11);
    check("t4_idx", 32'(idx), 32'd0);
    check("t4_last", 32'(last), 32'd1);
    ready = 1;
    tick();
    check("t4_done_valid", 32'(valid), 32'd0);
    ready = 0; mb = 4'b0000;

    // Clear during a two-beat report
    clear = 1; tick(); clear = 0;
    mb = 4'b0110;
    tick(16);
    check("t5_valid", 32'(valid), 32'd1);
    check("t5_idx", 32'(idx), 32'd1);
    check("t5_last", 32'(last), 32'd0);
    ready = 1; clear = 1;
    tick();
    clear = 0; mb = 4'b0000;
    check("t5_state", 32'(dut.state_q), 32'(ST_WATCH));
    check("t5_dl", 32'(dl), 32'd0);
    check("t5_valid_off", 32'(valid), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
`ifdef ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN
    check("t5_fa", 32'(fa), 32'd0);
`endif
    tick(3);
    check("t5_no_beat", 32'(valid), 32'd0);
    check("t5_dl_low", 32'(dl), 32'd0);
    ready = 0;

    // PERSIST_CYCLES=1 instance
    arm1 = 1;
    tick();
    mb1 = 4'b1000;
    tick();
    mb1 = 4'b0000;
    check("t6_valid", 32'(valid1), 32'd1);
    check("t6_idx", 32'(idx1), 32'd3);
    check("t6_last", 32'(last1), 32'd1);
    check("t6_dl", 32'(dl1), 32'd1);
    check("t6_onset", onset1, 32'd0);
    ready1 = 1;
    tick();
    check("t6_halt_valid", 32'(valid1), 32'd0);
    check("t6_halt_dl", 32'(dl1), 32'd1);

    // Reset in the middle of a report
    mb = 4'b0011;
    tick(16);
    check("t7_valid", 32'(valid), 32'd1);
    reset = 1;
    tick();
    check("t7_valid_rst", 32'(valid), 32'd0);
    check("t7_dl_rst", 32'(dl), 32'd0);
    check("t7_busy_rst", 32'(busy), 32'd0);
    check("t7_idx_rst", 32'(idx), 32'd0);
    check("t7_onset_rst", onset, 32'd0);
    check("t7_last_rst", 32'(last), 32'd0);
    check("t7_state_rst", 32'(dut.state_q), 32'(ST_IDLE));
    check("t7_dut1_dl_rst", 32'(dl1), 32'd0);
    reset = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/accelerator_hls_deadlock_report_ctrl.md
Name: accelerator_hls_deadlock_report_ctrl

Overview:
- Controller that sits above the per-process HLS deadlock monitors of the accelerator dataflow region.
- Arms and disarms detection, and confirms a deadlock only when monitor block persists.
- Latches which processes were blocked and when blocking began, then streams one report beat per blocked process over a valid/ready interface to the debug/status logic.
- Holds a sticky deadlock flag until software clears it.

Parameters:
- NUM_PROC, 4: number of monitored processes; width of monitor_block. Legal range 1..32.
- PERSIST_CYCLES, 16: consecutive cycles of any block needed to declare a deadlock. Legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the persistence counter.
- TS_W, 32: width of the onset timestamp counter.

Ports:
- clock  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high reset
- arm  in  1  level; enables detection
- clear  in  1  single-cycle pulse; clears the sticky result and latched state
- monitor_block  in  NUM_PROC  per-process block output of the HLS deadlock monitors
- deadlock  out  1  sticky; high from confirmation until clear or reset
- busy  out  1  high in CONFIRM or REPORT
- report_valid  out  1  report beat available
- report_ready  in  1  consumer accepts beat
- report_idx  out  $clog2(NUM_PROC) (min 1)  index of a blocked process
- report_onset  out  TS_W  timestamp of the first block cycle of the confirmed episode
- report_last  out  1  final beat of the report

Behaviour:
- Reset: state=IDLE. deadlock, busy, report_valid, report_last = 0; report_idx, report_onset = 0; all counters and masks = 0.
- States: IDLE, WATCH, CONFIRM, REPORT, HALT.
- ts counter:
  - cleared on IDLE->WATCH.
  - Increments every cycle outside IDLE.
  - Saturates at all-ones; never wraps.
- IDLE: if arm, go to WATCH on the next cycle.
- WATCH:
  - If arm=0, go to IDLE.
  - Otherwise, if |monitor_block: onset<=ts, mask<=monitor_block, cnt<=1. Go to REPORT if PERSIST_CYCLES==1, else CONFIRM.
- CONFIRM:
  - If arm=0, go to IDLE.
  - Else if monitor_block==0, go to WATCH (glitch). Discard mask and onset.
  - Else mask<=mask|monitor_block, cnt<=cnt+1. When cnt+1==PERSIST_CYCLES, go to REPORT.
- Detection latency: deadlock rises exactly PERSIST_CYCLES cycles after the first sampled block cycle. It is registered and goes high on the first REPORT cycle.
- REPORT:
  - report_valid=1; mask is guaranteed nonzero.
  - report_idx = lowest set bit of pending mask.
  - report_last = pending mask has exactly one bit set.
  - report_onset = latched onset.
  - On valid&ready, clear that bit. If report_last, go to HALT.
  - Payload must stay stable while valid & !ready.
  - arm is ignored.
  - monitor_block changes after entry do not alter the mask.
- HALT: deadlock held high; report_valid=0; arm ignored.
- clear:
  - Takes priority in every state.
  - Next state is WATCH if arm=1, else IDLE.
  - deadlock<=0, mask<=0, cnt<=0, ts<=0.
  - A beat offered in the same cycle as clear is dropped, even if ready=1.
- arm and a block in the same WATCH cycle: the block is sampled, because arm=1 is already true.
- reset mid-REPORT: all outputs return to reset values on the next edge. No partial beat persists.

Optional Feature:
- Macro: ACCEL_DEADLOCK_FALSE_ALARM_CNT_EN.
- Defined:
  - Adds output false_alarm_cnt (16 bits).
  - Increments, saturating, on each CONFIRM->WATCH glitch exit.
  - Cleared by reset and clear.
  - Not cleared on arm changes.
- Undefined: the port and counter do not exist. The rest of the behaviour is identical.

Decomposition:
- Shared package accelerator_hls_deadlock_pkg holds:
  - state enum (IDLE/WATCH/CONFIRM/REPORT/HALT)
  - default PERSIST_CYCLES
  - the 16-bit false-alarm width constant
- One sub-module: accelerator_hls_deadlock_ffs. Combinational lowest-set-bit finder plus single-bit detect over NUM_PROC; used by the REPORT state.

Test Plan:
- Reset then arm=1, monitor_block=0 for 100 cycles -> state WATCH; deadlock=0, report_valid=0.
- Defaults. monitor_block=4'b0010 from ts=5, held steady; ready=1 -> deadlock rises 16 cycles after first sample. Exactly one beat: idx=1, onset=5, last=1. Then HALT with deadlock=1.
- Block 4'b0001 for 3 cycles, then 4'b0100 for 16 cycles -> mask accumulates to 0101. Beats idx=0 (last=0), then idx=2 (last=1); ready held low 4 cycles on beat 0 with payload stable.
- Block high for 10 cycles, then 0 for 1 cycle, then high again -> no deadlock at cycle 16. With the macro, false_alarm_cnt=1. Confirmation occurs 16 cycles after re-onset, with the new onset.
- In REPORT with 2 beats pending, pulse clear with arm=1 -> next cycle state WATCH, deadlock=0, report_valid=0. No further beats.
- PERSIST_CYCLES=1: single-cycle block 4'b1000 -> REPORT next cycle; idx=3, last=1.
